// File: rtl/divisor_seq_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between the ALU opcode decoder
// and the sequential divider.
interface divisor_seq_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero;
    logic             ov;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_zero, ov
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_zero, ov
    );
endinterface

// File: rtl/divisor_seq_ctrl.sv
// Multicycle restoring divider for the ALU: one shift/subtract step per clock,
// WIDTH steps per operation, registered quotient/remainder with a done pulse.
module divisor_seq_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    divisor_seq_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic [CNT_W-1:0]   cnt;

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   r_q;
    logic               div_zero_q;
    logic               ov_q;

    logic [WIDTH:0]     trial_c;
    logic [WIDTH-1:0]   rem_nxt_c;
    logic [WIDTH-1:0]   quo_nxt_c;

    // One restoring iteration: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        trial_c   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        rem_nxt_c = {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo_nxt_c = {quo[WIDTH-2:0], 1'b0};
        if (!trial_c[WIDTH]) begin
            rem_nxt_c = trial_c[WIDTH-1:0];
            quo_nxt_c = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (bus.b == '0) begin
                            // Divide-by-zero bypasses iteration and reports immediately.
                            state      <= S_DONE;
                            q_q        <= '1;
                            r_q        <= bus.a;
                            div_zero_q <= 1'b1;
                            ov_q       <= 1'b1;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state  <= S_DIV;
                            rem    <= '0;
                            quo    <= bus.a;
                            dvs    <= bus.b;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                        end
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_DIV: begin
                    rem <= rem_nxt_c;
                    quo <= quo_nxt_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state      <= S_DONE;
                        q_q        <= quo_nxt_c;
                        r_q        <= rem_nxt_c;
                        div_zero_q <= 1'b0;
                        ov_q       <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.div_zero = div_zero_q;
    assign bus.ov       = ov_q;
endmodule
